// File: rtl/osg_pkg.sv
// Shared definitions for the status UART transmitter: FSM state encoding,
// 8N1 frame constants and the bit-period calculation.
package osg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per serial bit, truncated; no fractional correction is applied.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the transmitter; full/empty are registered alongside
// the occupancy count so they always agree with it.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_Tx,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic [AW:0]   w_count_nxt;
  logic          w_push_ok;
  logic          w_pop_ok;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok = push & ~r_full;
  assign w_pop_ok  = pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk_Tx or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk_Tx) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/uart_status_tx.sv
// 8N1 transmitter draining a small byte FIFO toward the PC; frames run
// back-to-back while bytes are queued.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bits, LSB first
// STOP  | stop bit (1); at its end chain straight into the next frame if queued
module uart_status_tx
  import osg_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_Tx,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       Tx_out
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CW-1:0]    BAUD_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0]    BAUD_ONE  = CW'(1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_baud;
  logic [CW-1:0]    w_baud_nxt;
  logic [BIT_W-1:0] r_bit;
  logic [BIT_W-1:0] w_bit_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_tx;
  logic             w_tx_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_pop;
  logic             w_tc;
  logic [7:0]       w_head;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_Tx(clk_Tx),
    .rst_n (rst_n),
    .push  (wr),
    .din   (data_in),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (full),
    .empty (empty)
  );

  assign w_tc = (r_baud == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!empty) begin
          w_state_nxt = START;
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = BAUD_LOAD;
        end
      end

      START: begin
        if (w_tc) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_baud_nxt  = BAUD_LOAD;
        end else begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end
      end

      DATA: begin
        if (w_tc) begin
          w_baud_nxt = BAUD_LOAD;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + BIT_ONE;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end else begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end
      end

      STOP: begin
        if (w_tc) begin
          w_baud_nxt = BAUD_LOAD;
          if (r_bit == STOP_LAST) begin
            w_done_nxt = 1'b1;
            // Chain the next queued byte with no idle bit between frames.
            if (!empty) begin
              w_state_nxt = START;
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = IDLE;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + BIT_ONE;
          end
        end else begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_Tx or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy    = (r_state != IDLE);
  assign tx_done = r_done;
  assign Tx_out  = r_tx;

endmodule

// File: doc/uart_status_tx.md
UART_STATUS_TX -- requirements
Module: uart_status_tx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 4, byte FIFO depth; must be a power of two, at least 2.
REQ-004 Port clk_Tx, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port data_in, input, 8 bits: byte to transmit to the PC.
REQ-007 Port wr, input, 1 bit: write strobe; data_in is sampled when wr=1 and full=0.
REQ-008 Port full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-009 Port empty, output, 1 bit: FIFO holds 0 bytes.
REQ-010 Port busy, output, 1 bit: the FSM is not in IDLE.
REQ-011 Port tx_done, output, 1 bit: one-cycle pulse at the end of each stop bit.
REQ-012 Port Tx_out, output, 1 bit: serial line; idles high.

Function
REQ-013 Bit period DIV = CLK_HZ/BAUD, integer-truncated (5208 at the default parameters); every bit lasts exactly DIV clk_Tx cycles.
REQ-014 Frame format is 8N1: start bit 0, data bits LSB first (data_in[0] first), stop bit 1; frame length is exactly 10*DIV cycles.
REQ-015 The FSM has four states: IDLE, START, DATA, STOP.
REQ-016 IDLE to START occurs when empty=0; on that edge the FIFO head is popped into an 8-bit shift register, and Tx_out=0 is registered.
REQ-017 START to DATA occurs after DIV cycles; bit index resets to 0.
REQ-018 DATA advances the bit index every DIV cycles; after bit 7, the FSM goes to STOP.
REQ-019 STOP lasts DIV cycles, then tx_done=1 for one cycle.
REQ-020 At the end of STOP, if empty=0, the FSM enters START on the same edge with a pop (no idle gap); otherwise it enters IDLE.
REQ-021 Latency: wr sampled at edge N with the FSM idle and the FIFO empty gives Tx_out falling at edge N+1.
REQ-022 Tx_out is driven directly from a flop; no combinational path from any input reaches Tx_out.
REQ-023 A write is accepted only when full=0; wr while full=1 is dropped silently with no state change, even if a pop occurs on the same edge.
REQ-024 A write and a pop on the same edge with full=0 leaves the count unchanged; data order is preserved.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; the count is width log2(FIFO_DEPTH)+1 and never exceeds FIFO_DEPTH.
REQ-026 full and empty are registered and consistent with the count in the same cycle.
REQ-027 busy=1 in START, DATA and STOP, including during back-to-back frames.
REQ-028 The baud counter restarts at every state entry; no fractional-rate accumulation.

Reset
REQ-029 While rst_n=0, outputs are forced immediately, independent of clk_Tx: Tx_out=1, busy=0, tx_done=0, full=0, empty=1.
REQ-030 While rst_n=0, FSM=IDLE, FIFO pointers, count, baud counter and bit index are all cleared.
REQ-031 A reset asserted mid-frame aborts the frame immediately (line high) and discards all queued bytes.
REQ-032 After rst_n deasserts, the first wr is treated as into an empty FIFO (REQ-021).

Structure
REQ-033 A shared package osg_pkg holds: the FSM state enum (IDLE, START, DATA, STOP), the 8N1 frame constants (DATA_BITS=8, STOP_BITS=1), and the DIV computation function.
REQ-034 The FIFO is one sub-module, tx_fifo (parameter FIFO_DEPTH, 8-bit data, push/pop/full/empty); the FSM, baud counter and shifter stay in uart_status_tx.

Verification (CLK_HZ=1000, BAUD=100, DIV=10)
REQ-035 Single byte: wr with data_in=0xA5 at idle -> Tx_out falls at the next edge, then shows 0,1,0,1,0,0,1,0,1,1 at 10 cycles/bit; tx_done pulses at cycle 100; busy returns to 0.
REQ-036 Back-to-back: bytes 0x00 and 0xFF written on consecutive cycles -> two 100-cycle frames with no gap; tx_done pulses twice, 100 cycles apart.
REQ-037 Overflow: six writes 0x01..0x06 on consecutive cycles at idle -> 0x01 is popped at once, 0x02..0x05 are queued (full=1), 0x06 is dropped; the line shows 0x01..0x05 in order, then empty=1.
REQ-038 Simultaneous events: wr on the pop edge at end of STOP with count=1 -> count stays 1, no byte lost, order preserved.
REQ-039 Mid-frame reset: rst_n low at cycle 45 of a frame -> Tx_out=1 and empty=1 within the same cycle; after release, wr 0x3C -> a clean frame of 0x3C.
REQ-040 Idle check: 1000 cycles with no wr after reset -> Tx_out stays 1, busy=0, tx_done never pulses.
